// File: rtl/loadable_rom_pkg.sv
// Shared definitions for the loadable instruction ROM.
//   state_e      : control FSM encoding (run / load / commit)
//   NopDefault   : default fetch word returned while a load is in progress
//   DefaultWord* : built-in program present at power-up (remaining words are 0)
package loadable_rom_pkg;

  typedef enum logic [1:0] {
    StRun,
    StLoad,
    StCommit
  } state_e;

  localparam logic [31:0] NopDefault   = 32'h0000_0000;

  // Built-in program: addi x0,x0,0 followed by a jump-to-self.
  localparam logic [31:0] DefaultWord0 = 32'h0000_0013;
  localparam logic [31:0] DefaultWord1 = 32'h0000_006f;

endpackage

// File: rtl/loadable_rom_if.sv
// Fetch and program-load signals of the loadable ROM.
//   master : fetch stage / host byte source (drives addr and load_* requests)
//   slave  : the ROM (returns q, ready, busy and load status)
interface loadable_rom_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9
);

  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] q;
  logic                  load_start;
  logic                  load_byte_valid;
  logic [7:0]            load_byte;
  logic                  load_byte_ready;
  logic                  load_end;
  logic                  busy;
  logic [ADDR_WIDTH:0]   load_count;
  logic                  load_overflow;

  modport master (
    output addr, load_start, load_byte_valid, load_byte, load_end,
    input  q, load_byte_ready, busy, load_count, load_overflow
  );

  modport slave (
    input  addr, load_start, load_byte_valid, load_byte, load_end,
    output q, load_byte_ready, busy, load_count, load_overflow
  );

endinterface

// File: rtl/loadable_rom_word_packer.sv
// Packs a byte stream big-endian into DATA_WIDTH words.
//   clk, reset   : clock, synchronous active-high reset
//   clear        : drop any partially received word
//   byte_en      : byte_in is consumed this cycle
//   word_valid   : byte_in completes a word; word holds it (same cycle)
//   flush_word   : partial word so far, left-aligned, low bytes zero
//   pending_next : a partial word will be held after this cycle
module word_packer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_en,
  input  logic [7:0]            byte_in,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] flush_word,
  output logic                  pending_next
);

  localparam int unsigned BPW     = DATA_WIDTH / 8;
  localparam int unsigned IdxW    = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BPW - 1);

  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [IdxW-1:0]       idx_q, idx_d;

  // Bytes enter at the bottom and move up, so the first byte ends up on top.
  assign word       = (sr_q << 8) | DATA_WIDTH'(byte_in);
  assign word_valid = byte_en && (idx_q == LastIdx);

  // Shift the idx_q received bytes up to the top; stale upper bytes fall off.
  assign flush_word = sr_q << (8 * (BPW - 32'(idx_q)));

  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (clear) begin
      sr_d  = '0;
      idx_d = '0;
    end else if (byte_en) begin
      if (idx_q == LastIdx) begin
        sr_d  = '0;
        idx_d = '0;
      end else begin
        sr_d  = word;
        idx_d = idx_q + IdxW'(1);
      end
    end
  end

  assign pending_next = (idx_d != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/loadable_rom.sv
// Instruction memory with a 1-cycle synchronous fetch port and a runtime
// program-load port that packs a host byte stream into words written from 0.
//   clk, reset : clock, synchronous active-high reset
//   bus        : loadable_rom_if slave (fetch addr/q, load byte stream, status)
module loadable_rom
  import loadable_rom_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 9,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(NopDefault)
) (
  input  logic clk,
  input  logic reset,
  loadable_rom_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] q_q;

  logic [DATA_WIDTH-1:0] mem [Depth] = '{
    0:       DATA_WIDTH'(DefaultWord0),
    1:       DATA_WIDTH'(DefaultWord1),
    default: '0
  };

  logic                  full;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  accept;
  logic                  byte_en;
  logic                  packer_clear;
  logic                  word_valid;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] flush_word;
  logic                  pending_next;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // The write pointer always equals the word count; the count's MSB marks a
  // full memory, which also keeps the pointer from wrapping into address 0.
  assign full   = count_q[ADDR_WIDTH];
  assign ptr    = count_q[ADDR_WIDTH-1:0];
  assign accept = (state_q == StLoad) && bus.load_byte_valid;

  // A restart in the same cycle discards the byte; a full memory drains it.
  assign byte_en      = accept && !full && !bus.load_start;
  assign packer_clear = bus.load_start || (state_q == StCommit);

  word_packer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear       (packer_clear),
    .byte_en     (byte_en),
    .byte_in     (bus.load_byte),
    .word_valid  (word_valid),
    .word        (word),
    .flush_word  (flush_word),
    .pending_next(pending_next)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    mem_we    = 1'b0;
    mem_wdata = word;
    if (bus.load_start) begin
      // Start or restart; words already written stay in memory.
      state_d = StLoad;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StRun: ;
        StLoad: begin
          if (word_valid) begin
            mem_we  = 1'b1;
            count_d = count_q + (ADDR_WIDTH + 1)'(1);
          end
          if (accept && full) begin
            ovf_d = 1'b1;
          end
          if (bus.load_end) begin
            state_d = pending_next ? StCommit : StRun;
          end
        end
        StCommit: begin
          if (!full) begin
            mem_we    = 1'b1;
            mem_wdata = flush_word;
            count_d   = count_q + (ADDR_WIDTH + 1)'(1);
          end
          state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Memory contents survive reset; only an in-flight write is suppressed.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[ptr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else if (state_q != StRun) begin
      q_q <= NOP_WORD;
    end else begin
      q_q <= mem[bus.addr];
    end
  end

  assign bus.q               = q_q;
  assign bus.busy            = (state_q != StRun);
  assign bus.load_byte_ready = (state_q == StLoad);
  assign bus.load_count      = count_q;
  assign bus.load_overflow   = ovf_q;

endmodule

// File: tb/tb_loadable_rom.sv
// Self-checking bench for loadable_rom: table of fetch read-backs per phase
// plus directed load sequences (full words, partial commit, restart,
// overflow, simultaneous start/end, reset mid-load).
module tb_loadable_rom;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 2;
  localparam logic [31:0] Nop = 32'hdead_beef;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  loadable_rom_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  loadable_rom #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NOP_WORD  (Nop)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int            phase;
    logic [AW-1:0] addr;
    logic [31:0]   exp;
  } rd_vec_t;

  rd_vec_t rd_tab[$];

  task automatic add_rd(input int ph, input logic [AW-1:0] a, input logic [31:0] e);
    rd_vec_t v;
    v.phase = ph;
    v.addr  = a;
    v.exp   = e;
    rd_tab.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
  endtask

  task automatic pulse_end();
    bus.load_end = 1'b1;
    step();
    bus.load_end = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic with_end);
    bus.load_byte_valid = 1'b1;
    bus.load_byte       = b;
    bus.load_end        = with_end;
    step();
    bus.load_byte_valid = 1'b0;
    bus.load_end        = 1'b0;
  endtask

  task automatic fetch_phase(input int ph);
    foreach (rd_tab[i]) begin
      if (rd_tab[i].phase == ph) begin
        bus.addr = rd_tab[i].addr;
        step();
        chk($sformatf("rd_p%0d_a%0d", ph, rd_tab[i].addr), bus.q, rd_tab[i].exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Phase 0: built-in program.
    add_rd(0, 2'd0, 32'h0000_0013);
    add_rd(0, 2'd1, 32'h0000_006f);
    add_rd(0, 2'd2, 32'h0000_0000);
    add_rd(0, 2'd3, 32'h0000_0000);
    // Phase 1: two full words.
    add_rd(1, 2'd1, 32'h38b0_0000);
    add_rd(1, 2'd0, 32'h040f_8000);
    add_rd(1, 2'd2, 32'h0000_0000);
    // Phase 2: one full word plus committed partial.
    add_rd(2, 2'd1, 32'haabb_0000);
    add_rd(2, 2'd0, 32'h1122_3344);
    // Phase 3: restart rewrote word 0 only.
    add_rd(3, 2'd0, 32'hc0de_cafe);
    add_rd(3, 2'd1, 32'haabb_0000);
    // Phase 4: overflow run filled all four words.
    add_rd(4, 2'd0, 32'h0102_0304);
    add_rd(4, 2'd1, 32'h0506_0708);
    add_rd(4, 2'd2, 32'h090a_0b0c);
    add_rd(4, 2'd3, 32'h0d0e_0f10);
    // Phase 5: reset mid-load left memory alone.
    add_rd(5, 2'd0, 32'h0102_0304);

    reset               = 1'b1;
    bus.addr            = '0;
    bus.load_start      = 1'b0;
    bus.load_byte_valid = 1'b0;
    bus.load_byte       = '0;
    bus.load_end        = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_q", bus.q, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_count", 32'(bus.load_count), 32'h0);
    chk("rst_ovf", 32'(bus.load_overflow), 32'h0);
    chk("rst_ready", 32'(bus.load_byte_ready), 32'h0);
    fetch_phase(0);

    // Full-word load.
    pulse_start();
    chk("full_busy", 32'(bus.busy), 32'h1);
    chk("full_ready", 32'(bus.load_byte_ready), 32'h1);
    send(8'h04, 1'b0); send(8'h0f, 1'b0); send(8'h80, 1'b0); send(8'h00, 1'b0);
    send(8'h38, 1'b0); send(8'hb0, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    chk("full_q_nop", bus.q, Nop);
    pulse_end();
    chk("full_busy_fall", 32'(bus.busy), 32'h0);
    chk("full_count", 32'(bus.load_count), 32'h2);
    fetch_phase(1);

    // Partial word committed with load_end on the last byte.
    pulse_start();
    chk("part_count_clr", 32'(bus.load_count), 32'h0);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    send(8'haa, 1'b0); send(8'hbb, 1'b1);
    chk("commit_ready", 32'(bus.load_byte_ready), 32'h0);
    chk("commit_busy", 32'(bus.busy), 32'h1);
    chk("commit_count", 32'(bus.load_count), 32'h1);
    step();
    chk("part_busy_fall", 32'(bus.busy), 32'h0);
    chk("part_count", 32'(bus.load_count), 32'h2);
    fetch_phase(2);

    // Fetch while busy, then restart after three bytes.
    pulse_start();
    bus.addr = 2'd1;
    send(8'h01, 1'b0);
    chk("busy_q_a1", bus.q, Nop);
    bus.addr = 2'd0;
    send(8'h02, 1'b0);
    chk("busy_q_a0", bus.q, Nop);
    bus.addr = 2'd1;
    send(8'h03, 1'b0);
    chk("busy_q_a1b", bus.q, Nop);
    pulse_start();
    chk("restart_count", 32'(bus.load_count), 32'h0);
    chk("restart_busy", 32'(bus.busy), 32'h1);
    send(8'hc0, 1'b0); send(8'hde, 1'b0); send(8'hca, 1'b0); send(8'hfe, 1'b0);
    chk("restart_count1", 32'(bus.load_count), 32'h1);
    pulse_end();
    chk("restart_busy_fall", 32'(bus.busy), 32'h0);
    fetch_phase(3);

    // Overflow: 20 bytes into a 4-word memory.
    pulse_start();
    for (int i = 1; i <= 20; i++) begin
      send(8'(i), 1'b0);
      if (i == 16) begin
        chk("ovf_count16", 32'(bus.load_count), 32'h4);
        chk("ovf_clear16", 32'(bus.load_overflow), 32'h0);
      end
      if (i == 17) begin
        chk("ovf_set17", 32'(bus.load_overflow), 32'h1);
        chk("ovf_ready17", 32'(bus.load_byte_ready), 32'h1);
      end
    end
    chk("ovf_count20", 32'(bus.load_count), 32'h4);
    chk("ovf_ready20", 32'(bus.load_byte_ready), 32'h1);
    pulse_end();
    chk("ovf_busy_fall", 32'(bus.busy), 32'h0);
    chk("ovf_hold", 32'(bus.load_overflow), 32'h1);
    chk("ovf_count_hold", 32'(bus.load_count), 32'h4);
    fetch_phase(4);

    // Simultaneous start and end: start wins and the partial byte is dropped.
    pulse_start();
    send(8'hab, 1'b0);
    bus.load_start = 1'b1;
    bus.load_end   = 1'b1;
    step();
    bus.load_start = 1'b0;
    bus.load_end   = 1'b0;
    chk("both_ready", 32'(bus.load_byte_ready), 32'h1);
    chk("both_count", 32'(bus.load_count), 32'h0);
    pulse_end();
    chk("both_end_run", 32'(bus.busy), 32'h0);

    // Reset in the middle of a load.
    pulse_start();
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_count", 32'(bus.load_count), 32'h0);
    chk("midrst_ready", 32'(bus.load_byte_ready), 32'h0);
    chk("midrst_q", bus.q, 32'h0);
    fetch_phase(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/loadable_rom.md
Name: loadable_rom

Overview:
- Parametrised instruction memory for the processor fetch path.
- Synchronous read port with 1-cycle latency.
- Adds a runtime program-load port: a byte stream is packed big-endian into DATA_WIDTH words and written to consecutive addresses from 0, so a new program can replace the built-in one without resynthesis.
- Sits between the fetch stage (addr/q) and a host byte source such as a UART receiver.

Parameters:
- DATA_WIDTH, 32: instruction width; must be a multiple of 8.
- ADDR_WIDTH, 9: address width; depth = 2**ADDR_WIDTH words.
- NOP_WORD, 0: value driven on q while a load is in progress.
- BPW (localparam): DATA_WIDTH/8, bytes per word.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- addr  in  ADDR_WIDTH  fetch address.
- q  out  DATA_WIDTH  registered fetch data.
- load_start  in  1  pulse: begin or restart a load at address 0.
- load_byte_valid  in  1  host byte valid.
- load_byte  in  8  host byte.
- load_byte_ready  out  1  block accepts a byte this cycle.
- load_end  in  1  pulse: finish the load.
- busy  out  1  load in progress (LOAD or COMMIT); fetch output is invalid.
- load_count  out  ADDR_WIDTH+1  words written by the current or last load.
- load_overflow  out  1  sticky: bytes arrived after the memory was full.

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high.
- Reset values: q=0, busy=0, load_byte_ready=0, load_count=0, load_overflow=0, state=RUN; write pointer, byte index and shift register = 0.
- Reset does not clear memory contents.
- Memory powers up with the default program; entries not written read as 0.
- States: RUN, LOAD, COMMIT.
- RUN:
  - q <= mem[addr] every cycle, latency 1.
  - load_byte_ready=0.
  - load_start moves to LOAD next cycle and clears ptr, byte index, shift register, load_count and load_overflow.
  - load_end and byte inputs are ignored.
- LOAD:
  - busy=1, q <= NOP_WORD, load_byte_ready=1.
  - A byte transfers on valid && ready.
  - The first byte of a word goes to bits [DATA_WIDTH-1:DATA_WIDTH-8] (big-endian).
  - On the BPW-th byte, the full word is written to mem[ptr] in the same cycle; ptr and load_count increment and the byte index returns to 0.
  - When load_count == 2**ADDR_WIDTH: further accepted bytes are discarded, no write occurs, and load_overflow is set. ptr never wraps and ready stays 1 so the host drains.
- load_end in LOAD:
  - Any byte transferred in the same cycle is accepted first.
  - If the byte index is then 0, go to RUN.
  - Otherwise go to COMMIT.
- COMMIT (one cycle):
  - load_byte_ready=0.
  - Write the partial word to mem[ptr], received bytes left-aligned and remaining low bytes 0. Skip the write if the memory is full.
  - load_count increments, then go to RUN.
- load_start in LOAD or COMMIT restarts the load: the partial word is discarded and ptr and load_count are cleared; words already written remain.
- Simultaneous load_start and load_end: load_start wins.
- First valid fetch after a load: addr presented in the first RUN cycle gives q on the next edge.
- load_count and load_overflow hold after a load until the next load_start or reset.
- Reset during LOAD: return to RUN immediately and drop the partial word; memory keeps completed words.

Decomposition:
- Package loadable_rom_pkg holds the state encoding (RUN/LOAD/COMMIT) and the default NOP constant.
- One sub-module, word_packer: shift register plus byte index. It emits word_valid with the packed word on the BPW-th byte and a flush output with the zero-padded partial word. The top keeps the FSM, pointer, counters and memory.

Test Plan:
- Reset: assert reset for 2 cycles -> q=0, busy=0, load_count=0, load_overflow=0, load_byte_ready=0.
- Full-word load: load_start; bytes 04 0F 80 00 38 B0 00 00; load_end -> busy falls. Then addr=1 -> q=32'h38B00000 one cycle later; addr=0 -> 32'h040F8000; load_count=2.
- Partial word: bytes 11 22 33 44 AA BB with load_end in the same cycle as BB -> one COMMIT cycle (ready=0); mem[1]=32'hAABB0000; load_count=2.
- Overflow (ADDR_WIDTH=2): stream 20 bytes -> load_count=4, load_overflow=1 after byte 17, ready stays 1, mem[0..3] hold words 1..4.
- Reset mid-load: after 2 bytes assert reset -> next cycle busy=0, load_count=0; addr=0 returns the prior mem[0].
- Fetch during load: addr toggling while busy -> q=NOP_WORD every cycle; load_start during LOAD after 3 bytes -> next full word lands at address 0.
